muldiv_unit: RTL and testbench

Iterative RV32M/RV64M multiply-divide execution unit, the multi-cycle sibling of the combinational ALU decode path. It decodes funct7/funct3 of OP-class instructions with funct7 = 0000001, then runs a radix-2 shift-add multiplier or a restoring divider over XLEN cycles. Operands enter and results leave through valid/ready handshakes. It sits in the execute stage beside the ALU, and the pipeline stalls on in_ready/out_valid.

---
 rtl/muldiv_pkg.sv | 43 ++++
 rtl/muldiv_decode.sv | 19 +
 rtl/muldiv_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types, constants and op-class helpers for the iterative
// RV32M/RV64M multiply-divide unit.
//   op_e          : decoded operation, encoded so that op == funct3
//   state_e       : controller states
//   FUNCT7_MULDIV : the only legal funct7 for the M extension
//   is_div / is_signed_a / is_signed_b : operation class helpers
package muldiv_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        OpMul    = 3'b000,
        OpMulh   = 3'b001,
        OpMulhsu = 3'b010,
        OpMulhu  = 3'b011,
        OpDiv    = 3'b100,
        OpDivu   = 3'b101,
        OpRem    = 3'b110,
        OpRemu   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StFix  = 2'b10,
        StDone = 2'b11
    } state_e;

    function automatic logic is_div(input op_e op);
        return op inside {OpDiv, OpDivu, OpRem, OpRemu};
    endfunction

    // MUL's low half is sign-agnostic; treating it as signed keeps |op_b| small
    // for negative multipliers, which shortens the early-out path.
    function automatic logic is_signed_a(input op_e op);
        return op inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
    endfunction

    function automatic logic is_signed_b(input op_e op);
        return op inside {OpMul, OpMulh, OpDiv, OpRem};
    endfunction

endpackage

// File: rtl/muldiv_decode.sv
// muldiv_decode: combinational funct7/funct3 decoder for OP-class M-extension
// instructions.
//   funct7  in  7  instruction funct7
//   funct3  in  3  instruction funct3
//   op      out    decoded operation
//   illegal out 1  funct7 is not the M-extension encoding
module muldiv_decode
    import muldiv_pkg::*;
(
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    output op_e        op,
    output logic       illegal
);

    assign op      = op_e'(funct3);
    assign illegal = (funct7 != FUNCT7_MULDIV);

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide execution unit (radix-2 shift-add
// multiplier, restoring divider), one iteration per cycle.
//   clk, reset_n          clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (in_ready == idle)
//   funct7, funct3        instruction fields
//   op_a, op_b            rs1 / rs2 values
//   kill                  synchronous flush, wins over in_valid and out_ready
//   out_valid / out_ready result handshake
//   result, illegal       registered rd value and illegal-op flag
//   busy                  unit not idle
// Optional: define MULDIV_EARLY_OUT_EN to let multiplies leave CALC once the
// remaining multiplier bits are zero.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal,
    output logic            busy
);

    localparam int unsigned CntW = $clog2(XLEN);
    localparam logic [CntW-1:0] LastIter = CntW'(XLEN - 1);
    localparam logic [XLEN-1:0] MostNeg = {1'b1, {(XLEN - 1){1'b0}}};

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EarlyOut = 1'b1;
`else
    localparam bit EarlyOut = 1'b0;
`endif

    // Decode
    op_e  dec_op;
    logic dec_illegal;

    muldiv_decode u_decode (
        .funct7  (funct7),
        .funct3  (funct3),
        .op      (dec_op),
        .illegal (dec_illegal)
    );

    // State
    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;
    // acc: product (mul) or {remainder, dividend/quotient} (div)
    logic [2*XLEN-1:0] acc_q, acc_d;
    // mcand: shifting multiplicand (mul) or divisor in the low half (div)
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              illegal_q, illegal_d;

    // Operand conditioning at accept
    logic            sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf;

    assign sign_a   = is_signed_a(dec_op) && op_a[XLEN-1];
    assign sign_b   = is_signed_b(dec_op) && op_b[XLEN-1];
    assign mag_a    = sign_a ? -op_a : op_a;
    assign mag_b    = sign_b ? -op_b : op_b;
    assign div_zero = is_div(dec_op) && (op_b == '0);
    assign div_ovf  = (dec_op inside {OpDiv, OpRem}) && (op_a == MostNeg) && (op_b == '1);

    // Iteration datapath
    logic [2*XLEN-1:0] mul_sum;
    logic [XLEN:0]     div_shift, div_diff;
    logic              div_ok;
    logic              mul_early;

    assign mul_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, mcand_q[XLEN-1:0]};
    assign div_ok    = !div_diff[XLEN];
    // Product is already aligned with a shifting multiplicand, so leaving
    // early only needs the unconsumed multiplier bits to be zero.
    assign mul_early = EarlyOut && !is_div(op_q) && (mplier_q[XLEN-1:1] == '0);

    // Sign correction
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    logic [XLEN-1:0]   fix_result;

    assign prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    assign quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_fix  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        fix_result = '0;
        unique case (op_q)
            OpMul:                     fix_result = prod_fix[XLEN-1:0];
            OpMulh, OpMulhsu, OpMulhu: fix_result = prod_fix[2*XLEN-1:XLEN];
            OpDiv, OpDivu:             fix_result = quo_fix;
            OpRem, OpRemu:             fix_result = rem_fix;
            default:                   fix_result = '0;
        endcase
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        result_d  = result_q;
        illegal_d = illegal_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid && !kill) begin
                    op_d      = dec_op;
                    illegal_d = dec_illegal;
                    cnt_d     = '0;
                    neg_a_d   = sign_a;
                    neg_b_d   = sign_b;
                    if (dec_illegal) begin
                        result_d = '0;
                        state_d  = StDone;
                    end else if (div_zero) begin
                        result_d = (dec_op inside {OpDiv, OpDivu}) ? '1 : op_a;
                        state_d  = StDone;
                    end else if (div_ovf) begin
                        result_d = (dec_op == OpDiv) ? MostNeg : '0;
                        state_d  = StDone;
                    end else begin
                        if (is_div(dec_op)) begin
                            acc_d    = {{XLEN{1'b0}}, mag_a};
                            mcand_d  = {{XLEN{1'b0}}, mag_b};
                            mplier_d = '0;
                        end else begin
                            acc_d    = '0;
                            mcand_d  = {{XLEN{1'b0}}, mag_a};
                            mplier_d = mag_b;
                        end
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                cnt_d = cnt_q + CntW'(1);
                if (is_div(op_q)) begin
                    acc_d = div_ok ? {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                                   : {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                end else begin
                    acc_d    = mul_sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end
                if ((cnt_q == LastIter) || mul_early) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                result_d = fix_result;
                state_d  = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (kill) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            op_q      <= OpMul;
            cnt_q     <= '0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign result    = result_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        illegal;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        ill;
        logic [31:0] lat;
    } exp_t;

    exp_t sb_q[$];

    muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct7    (funct7),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .illegal   (illegal),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result from native wide arithmetic.
    function automatic logic [31:0] ref_result(input logic [6:0] f7, input logic [2:0] f3,
                                               input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        if (f7 != 7'b0000001) return 32'h0;
        ea = (f3 == 3'd1 || f3 == 3'd2) ? {{32{a[31]}}, a} : {32'h0, a};
        eb = (f3 == 3'd1) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        case (f3)
            3'd0:       return p[31:0];
            3'd1, 3'd2,
            3'd3:       return p[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'd5:       return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default:    return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mb;
        int n;
        if (f7 != 7'b0000001) return 1;
        if (f3[2]) begin
            if (b == 0) return 1;
            if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return 1;
            return 34;
        end
`ifdef MULDIV_EARLY_OUT_EN
        mb = ((f3 == 3'd0 || f3 == 3'd1) && b[31]) ? -b : b;
        n = 1;
        for (int i = 0; i < 32; i++) if (mb[i]) n = i + 1;
        return 2 + n;
`else
        mb = b;
        n = 34;
        return n;
`endif
    endfunction

    // Issue one op at a negedge, wait for its result, hold it for 'hold'
    // cycles and then hand it off.
    task automatic run_op(input string tag, input logic [6:0] f7, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_ill, input int hold);
        exp_t e;
        int   k;
        e.res = exp_res;
        e.ill = exp_ill;
        e.lat = 32'(exp_latency(f7, f3, a, b));
        sb_q.push_back(e);
        check({tag, "_ready_in"}, in_ready, 1'b1);
        funct7   = f7;
        funct3   = f3;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        k = 1;
        if (e.lat > 1) check({tag, "_busy"}, {in_ready, busy}, 2'b01);
        while (!out_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        e = sb_q.pop_front();
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_latency"}, k, e.lat);
        check({tag, "_result"}, result, e.res);
        check({tag, "_illegal"}, illegal, e.ill);
        if (!out_valid) begin
            kill = 1'b1;
            @(negedge clk);
            kill = 1'b0;
        end else begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check({tag, "_hold"}, {out_valid, result}, {1'b1, e.res});
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check({tag, "_after_hs"}, {in_ready, out_valid}, 2'b10);
        end
    endtask

    localparam logic [6:0] F7 = 7'b0000001;

    initial begin
        logic        seen;
        logic [2:0]  rf3;
        logic [31:0] ra, rb;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        funct7    = 7'h0;
        funct3    = 3'h0;
        op_a      = 32'h0;
        op_b      = 32'h0;
        kill      = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("reset_outputs", {in_ready, out_valid, result, illegal, busy},
              {1'b1, 1'b0, 32'h0, 1'b0, 1'b0});
        reset_n = 1'b1;
        @(negedge clk);

        // Multiply
        run_op("mul_7_m3",   F7, 3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 0);
        run_op("mulh_min",   F7, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 0);
        run_op("mulhu_max",  F7, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 0);
        run_op("mulhsu_max", F7, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("mul_early",  F7, 3'd0, 32'd12345,     32'd3,         32'd37035,     1'b0, 0);

        // Divide
        run_op("div_m7_2",   F7, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 0);
        run_op("rem_m7_2",   F7, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("divu_100_7", F7, 3'd5, 32'd100,       32'd7, 32'd14,        1'b0, 5);
        run_op("remu_100_7", F7, 3'd7, 32'd100,       32'd7, 32'd2,         1'b0, 0);

        // Special cases
        run_op("div_by0",  F7, 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("rem_by0",  F7, 3'd6, 32'd5, 32'd0, 32'd5,         1'b0, 0);
        run_op("div_ovf",  F7, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0);
        run_op("rem_ovf",  F7, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0, 0);
        run_op("illegal",  7'b0100000, 3'd0, 32'd3, 32'd4, 32'h0, 1'b1, 2);

        // Random operations against the reference model
        for (int i = 0; i < 8; i++) begin
            rf3 = 3'($urandom_range(7));
            ra  = $urandom;
            rb  = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 40));
            run_op("rand", F7, rf3, ra, rb, ref_result(F7, rf3, ra, rb), 1'b0, 0);
        end

        // kill in cycle 10 of CALC
        funct7   = F7;
        funct3   = 3'd5;
        op_a     = 32'd1000;
        op_b     = 32'd3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_idle", {in_ready, busy}, 2'b10);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("kill_no_valid", seen, 1'b0);

        // kill wins over in_valid
        in_valid = 1'b1;
        kill     = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        kill     = 1'b0;
        check("kill_beats_accept", {in_ready, busy}, 2'b10);

        // Leave a nonzero result behind, then reset mid-CALC
        run_op("pre_reset", F7, 3'd0, 32'd9, 32'd9, 32'd81, 1'b0, 0);
        funct3   = 3'd0;
        op_a     = 32'h1234_5678;
        op_b     = 32'h8765_4321;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("reset_mid_calc", {in_ready, out_valid, result, illegal, busy},
              {1'b1, 1'b0, 32'h0, 1'b0, 1'b0});
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_op("post_reset", F7, 3'd5, 32'd100, 32'd10, 32'd10, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
